bin2bcd_seq: RTL

Sequential double-dabble binary-to-BCD converter feeding the 4-digit seven-segment display path.
- Takes a WIDTH-bit ALU result and produces Ones/Tens/Hundreds BCD digits plus a sign flag.
- The display digit mux selects these per-digit values using the 2-bit anode selector.
- Handshake is start/busy/done.
- Outputs hold the last completed result so the display never shows partial conversions.

---
 rtl/bin2bcd_seq_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done handshake and BCD result bundle for bin2bcd_seq
interface bin2bcd_seq_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Bin_In;
    logic             Busy;
    logic             Done;
    logic [3:0]       Ones;
    logic [3:0]       Tens;
    logic [3:0]       Hundreds;
    logic             Neg;

    modport master (
        output Start, Bin_In,
        input  Busy, Done, Ones, Tens, Hundreds, Neg
    );

    modport slave (
        input  Start, Bin_In,
        output Busy, Done, Ones, Tens, Hundreds, Neg
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter (3 digits + sign)
// Optional two's-complement input handling is enabled by defining SIGNED_INPUT_EN.
module bin2bcd_seq #(
    parameter int WIDTH = 8
) (
    input logic          Clk,
    input logic          Reset,
    bin2bcd_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [11:0]      scratch;
    logic [10:0]      scratch_adj;
    logic [WIDTH-1:0] mag_in;
    logic             done_q;
    logic [3:0]       ones_q;
    logic [3:0]       tens_q;
    logic [3:0]       hund_q;

    function automatic logic [3:0] adj3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Hundreds stays <= 2 before the final shift, so its top bit is always zero
    // and only the low 11 bits of the adjusted scratch survive the shift.
    function automatic logic [10:0] adj_scratch(input logic [11:0] s);
        logic [3:0] h;
        h = adj3(s[11:8]);
        return {h[2:0], adj3(s[7:4]), adj3(s[3:0])};
    endfunction

    assign scratch_adj = adj_scratch(scratch);

`ifdef SIGNED_INPUT_EN
    logic sign_in;
    logic sign_q;
    logic neg_q;

    // A WIDTH-bit unsigned field already holds 2^(WIDTH-1), so negating in
    // WIDTH bits covers the most-negative input.
    assign sign_in = bus.Bin_In[WIDTH-1];
    assign mag_in  = sign_in ? (~bus.Bin_In + 1'b1) : bus.Bin_In;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.Start)
                sign_q <= sign_in;
            if (state == S_DONE)
                neg_q <= sign_q;
        end
    end

    assign bus.Neg = neg_q;
`else
    assign mag_in  = bus.Bin_In;
    assign bus.Neg = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sreg    <= '0;
            scratch <= '0;
            done_q  <= 1'b0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            hund_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        sreg    <= mag_in;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // One settle edge after the last shift keeps latency at WIDTH+2.
                    if (cnt != '0) begin
                        scratch <= {scratch_adj, sreg[WIDTH-1]};
                        sreg    <= {sreg[WIDTH-2:0], 1'b0};
                        cnt     <= cnt - CW'(1);
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ones_q <= scratch[3:0];
                    tens_q <= scratch[7:4];
                    hund_q <= scratch[11:8];
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy     = (state != S_IDLE);
    assign bus.Done     = done_q;
    assign bus.Ones     = ones_q;
    assign bus.Tens     = tens_q;
    assign bus.Hundreds = hund_q;
endmodule
